// File: rtl/f2m_msqr.sv
// ============================================================================
// Module   : f2m_msqr
// Purpose  : Sequential multi-squarer over F_{2^m}: z = a^(2^k) mod f(x),
//            one (or, with F2M_MSQR_DOUBLE_EN defined, two) squarings per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module f2m_msqr #(
    parameter int            M  = 163,
    parameter logic [M-1:0]  FX = 'hC9,
    parameter int            KW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [M-1:0]  a,
    input  logic [KW-1:0] k,
    output logic          busy,
    output logic          done,
    output logic [M-1:0]  z
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    // Squaring in GF(2) spreads bits to even positions; the upper half is then
    // folded down using x^M == FX, highest term first so folds never reappear.
    function automatic logic [M-1:0] sqr(input logic [M-1:0] x);
        logic [2*M-2:0] t;
        t = '0;
        for (int i = 0; i < M; i++) begin
            t[2*i] = x[i];
        end
        for (int i = 2*M-2; i >= M; i--) begin
            if (t[i]) begin
                t[i]           = 1'b0;
                t[i-M +: M]    = t[i-M +: M] ^ FX;
            end
        end
        return t[M-1:0];
    endfunction

    logic [1:0]    state_q, state_d;
    logic [M-1:0]  r_q, r_d;
    logic [M-1:0]  z_q, z_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [M-1:0]  sq1;

    assign sq1 = sqr(r_q);

`ifdef F2M_MSQR_DOUBLE_EN
    logic [M-1:0]  sq2;
    assign sq2 = sqr(sq1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (k == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
`ifdef F2M_MSQR_DOUBLE_EN
                if (cnt_q <= KW'(2)) begin
                    state_d = S_FIN;
                end
`else
                if (cnt_q <= KW'(1)) begin
                    state_d = S_FIN;
                end
`endif
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        r_d    = r_q;
        cnt_d  = cnt_q;
        z_d    = z_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    r_d    = a;
                    cnt_d  = k;
                    busy_d = 1'b1;
                end
            end
            S_RUN: begin
`ifdef F2M_MSQR_DOUBLE_EN
                // An odd remaining count finishes with a single squaring.
                if (cnt_q == KW'(1)) begin
                    r_d   = sq1;
                    cnt_d = '0;
                end else begin
                    r_d   = sq2;
                    cnt_d = cnt_q - KW'(2);
                end
`else
                r_d   = sq1;
                cnt_d = cnt_q - KW'(1);
`endif
            end
            S_FIN: begin
                z_d    = r_q;
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            z_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            z_q    <= z_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;

endmodule

`default_nettype wire

// File: tb/tb_f2m_msqr.sv
// ============================================================================
// Module   : tb_f2m_msqr
// Purpose  : Scoreboard bench for f2m_msqr against a multiply-based GF(2^m)
//            reference model; honours F2M_MSQR_DOUBLE_EN for latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_f2m_msqr;

    localparam int           M  = 163;
    localparam int           KW = 8;
    localparam logic [M-1:0] FX = 163'hC9;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [M-1:0]  a_in  = '0;
    logic [KW-1:0] k_in  = '0;
    logic          busy;
    logic          done;
    logic [M-1:0]  z;

    f2m_msqr #(.M(M), .FX(FX), .KW(KW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a_in),
        .k     (k_in),
        .busy  (busy),
        .done  (done),
        .z     (z)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [M-1:0] zexp;
        int           when;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference: general field multiply (Horner, multiply-by-x with reduction)
    function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
        logic c;
        c = v[M-1];
        v = v << 1;
        if (c) v = v ^ FX;
        return v;
    endfunction

    function automatic logic [M-1:0] gmul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [M-1:0] p;
        p = '0;
        for (int i = M-1; i >= 0; i--) begin
            p = xtime(p);
            if (y[i]) p = p ^ x;
        end
        return p;
    endfunction

    function automatic logic [M-1:0] ref_msq(input logic [M-1:0] x, input int kk);
        logic [M-1:0] r;
        r = x;
        for (int i = 0; i < kk; i++) r = gmul(r, r);
        return r;
    endfunction

    // Negedges from the one before the start edge to the one showing done.
    function automatic int latency(input int kk);
`ifdef F2M_MSQR_DOUBLE_EN
        return (kk + 1) / 2 + 2;
`else
        return kk + 2;
`endif
    endfunction

    function automatic logic [M-1:0] rand_elem();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[M-1:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_done got=1 want=0 cycle=%0d", cyc);
            end else begin
                mon_e = sbq.pop_front();
                total++;
                if (z !== mon_e.zexp) begin
                    bad++;
                    $display("FAIL z_result got=%h want=%h", z, mon_e.zexp);
                end
                total++;
                if (cyc != mon_e.when) begin
                    bad++;
                    $display("FAIL done_latency got=%0d want=%0d", cyc, mon_e.when);
                end
            end
        end
    end

    // Called at a negedge; a and k are scrambled afterwards since the DUT latched them.
    task automatic issue(input logic [M-1:0] av, input logic [KW-1:0] kv, input logic [M-1:0] zexp);
        exp_t e;
        a_in   = av;
        k_in   = kv;
        start  = 1'b1;
        e.zexp = zexp;
        e.when = cyc + latency(int'(kv));
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a_in  = rand_elem();
        k_in  = KW'($urandom());
    endtask

    task automatic wait_done();
        int n;
        bit busy_ok;
        n       = 0;
        busy_ok = 1'b1;
        while (!done && n < 400) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL done_timeout got=0 want=1 after %0d cycles", n);
        end else begin
            total++;
            if (!busy_ok || busy !== 1'b0) begin
                bad++;
                $display("FAIL busy_window got=busy_ok:%0d,busy_at_done:%0b want=1,0", busy_ok, busy);
            end
        end
    endtask

    logic [M-1:0] ra;
    logic [M-1:0] zhold;
    bit           seen;
    int           kr;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || z !== '0) begin
            bad++;
            $display("FAIL reset_state got=busy:%0b done:%0b z:%h want=0,0,0", busy, done, z);
        end
        rst_n = 1'b1;
        @(negedge clk);

        issue(M'(1), KW'(5), M'(1));
        wait_done();
        issue(M'(1) << 82, KW'(1), M'('h192));
        wait_done();
        issue(M'(1) << 81, KW'(1), M'(1) << 162);
        wait_done();

        // Frobenius period and identity
        for (int i = 0; i < 3; i++) begin
            ra = rand_elem();
            issue(ra, KW'(163), ra);
            wait_done();
            ra = rand_elem();
            issue(ra, KW'(0), ra);
            wait_done();
        end

        // Start while busy is ignored; next start lands on the done cycle
        issue(M'(2), KW'(3), M'('h100));
        start = 1'b1;
        a_in  = M'(3);
        k_in  = KW'(2);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        issue(M'(2), KW'(2), M'('h10));
        wait_done();
        zhold = M'('h10);
        repeat (4) @(negedge clk);
        total++;
        if (z !== zhold) begin
            bad++;
            $display("FAIL z_hold got=%h want=%h", z, zhold);
        end

        // Reset in the middle of a long run
        a_in  = M'(2);
        k_in  = KW'(100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_mid_run got=%0b want=1", busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || z !== '0) begin
            bad++;
            $display("FAIL async_reset got=busy:%0b done:%0b z:%h want=0,0,0", busy, done, z);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (120) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL done_after_reset got=1 want=0");
        end
        issue(M'(2), KW'(1), M'(4));
        wait_done();

        // Random operands and counts, with random idle gaps (zero gap = back-to-back)
        for (int i = 0; i < 40; i++) begin
            ra = rand_elem();
            kr = $urandom_range(0, 255);
            issue(ra, KW'(kr), ref_msq(ra, kr));
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL pending_results got=%0d want=0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
